// File: rtl/irq_ctrl_if.sv
// Register bus between device_mux and the interrupt controller slave port.
// Byte strobes qualify the access; ack is returned by the slave.
interface irq_ctrl_if;
    logic [15:0] data_write;
    logic [15:0] data_read;
    logic [7:0]  addr;
    logic        uds;
    logic        lds;
    logic        rw;
    logic        ack;

    modport master (
        output data_write, addr, uds, lds, rw,
        input  data_read, ack
    );

    modport slave (
        input  data_write, addr, uds, lds, rw,
        output data_read, ack
    );
endinterface

// File: rtl/irq_ctrl.sv
// TG68 interrupt controller: latches peripheral requests, masks them, maps them to 68k levels
// and presents the highest active level on ipl_n. Registers sit behind a strobe/ack slave port.
module irq_ctrl #(
    parameter int unsigned NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    irq_ctrl_if.slave          bus,
    output logic [2:0]         ipl_n
);

    logic [NUM_SRC-1:0]      s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [NUM_SRC-1:0]      pending_q, pending_d;
    logic [NUM_SRC-1:0]      enable_q, enable_d;
    logic [NUM_SRC-1:0]      edge_mode_q, edge_mode_d;
    logic [NUM_SRC-1:0][2:0] prio_q, prio_d;
    logic                    ack_q, ack_d;
    logic [15:0]             data_read_q, data_read_d;
    logic [2:0]              lvl_q, lvl_d;

    logic               access, commit, wr, rd;
    logic [6:0]         word;
    logic [NUM_SRC-1:0] active, w1c, edge_set;
    logic [2:0]         win_idx, win_prio;
    logic [15:0]        prio_lo, prio_hi, rdata;
    logic               unused_bits;

    assign access = bus.uds | bus.lds;
    // The edge where ack goes 0->1 is the single commit point of an access.
    assign commit = access & ~ack_q;
    assign wr     = commit & ~bus.rw;
    assign rd     = commit & bus.rw;
    assign word   = bus.addr[7:1];

    assign unused_bits = ^{bus.addr[0], bus.data_write[15], bus.data_write[11],
                           bus.data_write[7], bus.data_write[3]};

    always_comb begin
        active = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            active[i] = pending_q[i] & enable_q[i] & (prio_q[i] != 3'd0);
        end
    end

    // Strict '>' keeps the lowest index on a priority tie.
    always_comb begin
        win_idx  = 3'd0;
        win_prio = 3'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (active[i] && (prio_q[i] > win_prio)) begin
                win_prio = prio_q[i];
                win_idx  = 3'(i);
            end
        end
    end

    always_comb begin
        prio_lo = '0;
        prio_hi = '0;
        for (int i = 0; i < 4; i++) begin
            prio_lo[4*i +: 3] = prio_q[i];
            prio_hi[4*i +: 3] = prio_q[i+4];
        end
    end

    always_comb begin
        rdata = '0;
        case (word)
            7'd0:    rdata[7:0] = pending_q;
            7'd1:    rdata[7:0] = enable_q;
            7'd2:    rdata[7:0] = edge_mode_q;
            7'd3:    rdata      = {win_prio != 3'd0, 12'd0, win_idx};
            7'd4:    rdata      = prio_lo;
            7'd5:    rdata      = prio_hi;
            default: rdata      = '0;
        endcase
    end

    always_comb begin
        s1_d        = irq_src;
        s2_d        = s1_q;
        s3_d        = s2_q;
        enable_d    = enable_q;
        edge_mode_d = edge_mode_q;
        prio_d      = prio_q;
        w1c         = '0;
        if (wr) begin
            case (word)
                7'd0: if (bus.lds) w1c = bus.data_write[7:0];
                7'd1: if (bus.lds) enable_d = bus.data_write[7:0];
                7'd2: if (bus.lds) edge_mode_d = bus.data_write[7:0];
                7'd4, 7'd5: begin
                    if (bus.lds) begin
                        prio_d[{word[0], 2'd0}] = bus.data_write[2:0];
                        prio_d[{word[0], 2'd1}] = bus.data_write[6:4];
                    end
                    if (bus.uds) begin
                        prio_d[{word[0], 2'd2}] = bus.data_write[10:8];
                        prio_d[{word[0], 2'd3}] = bus.data_write[14:12];
                    end
                end
                default: ;
            endcase
        end

        // Edge set is applied after W1C so a coincident new edge is not lost.
        edge_set = s2_q & ~s3_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            pending_d[i] = edge_mode_q[i] ? ((pending_q[i] & ~w1c[i]) | edge_set[i]) : s2_q[i];
        end

        ack_d       = access;
        data_read_d = rd ? rdata : data_read_q;
        lvl_d       = win_prio;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            pending_q   <= '0;
            enable_q    <= '0;
            edge_mode_q <= '0;
            prio_q      <= '0;
            ack_q       <= 1'b0;
            data_read_q <= '0;
            lvl_q       <= 3'd0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            edge_mode_q <= edge_mode_d;
            prio_q      <= prio_d;
            ack_q       <= ack_d;
            data_read_q <= data_read_d;
            lvl_q       <= lvl_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.data_read = data_read_q;
    assign ipl_n         = ~lvl_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: register vectors from a table, read data checked through a
// scoreboard queue on each ack rise, plus hand-written latency and corner-case sequences.
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_src;
    logic [2:0] ipl_n;

    irq_ctrl_if bus ();

    irq_ctrl #(.NUM_SRC(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_src (irq_src),
        .bus     (bus),
        .ipl_n   (ipl_n)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int acks_seen = 0;
    int acks_exp = 0;

    typedef struct {
        string       name;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic        uds;
        logic        lds;
        logic        rw;
        logic [15:0] exp;
        string       name;
    } vec_t;
    vec_t vt[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    logic ack_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.ack && !ack_prev) begin
            acks_seen++;
            if (bus.rw) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL sb_underflow: unexpected read ack, data %h", bus.data_read);
                end else begin
                    mon_e = sb.pop_front();
                    check(mon_e.name, bus.data_read, mon_e.data);
                end
            end
        end
        ack_prev = bus.ack;
    end

    // Called just after a posedge; returns just after a posedge with strobes low and ack clear.
    task automatic bus_access(input logic [7:0] a, input logic [15:0] d, input logic u,
                              input logic l, input logic r, input string name,
                              input logic [15:0] exp);
        exp_t e;
        int   k;
        if (r) begin
            e.name = name;
            e.data = exp;
            sb.push_back(e);
        end
        bus.addr = a;
        bus.data_write = d;
        bus.uds = u;
        bus.lds = l;
        bus.rw = r;
        acks_exp++;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!bus.ack && k < 8);
        if (!bus.ack) begin
            n_chk++;
            $display("FAIL ack_timeout %s: ack %b, want 1", name, bus.ack);
        end
        bus.uds = 1'b0;
        bus.lds = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        bus_access(a, d, 1'b1, 1'b1, 1'b0, "wr", 16'h0);
    endtask

    task automatic rd(input logic [7:0] a, input logic [15:0] exp, input string name);
        bus_access(a, 16'h0, 1'b1, 1'b1, 1'b1, name, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        irq_src = '0;
        bus.uds = 1'b0;
        bus.lds = 1'b0;
        wait_clks(1);
        reset = 1'b0;
        wait_clks(1);
    endtask

    task automatic add(input logic [7:0] a, input logic [15:0] d, input logic u, input logic l,
                       input logic r, input logic [15:0] exp, input string name);
        vec_t v;
        v.addr = a; v.wdata = d; v.uds = u; v.lds = l; v.rw = r; v.exp = exp; v.name = name;
        vt.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        irq_src = '0;
        bus.addr = '0;
        bus.data_write = '0;
        bus.uds = 1'b0;
        bus.lds = 1'b0;
        bus.rw = 1'b1;
        wait_clks(2);
        check("reset_ack", 16'(bus.ack), 16'h0);
        check("reset_data_read", bus.data_read, 16'h0);
        check("reset_ipl", 16'(ipl_n), 16'h7);
        reset = 1'b0;
        wait_clks(1);

        // Reset values, unmapped addresses, field masking and byte lanes.
        add(8'h00, 16'h0, 1, 1, 1, 16'h0000, "rd_pending_rst");
        add(8'h02, 16'h0, 1, 1, 1, 16'h0000, "rd_enable_rst");
        add(8'h04, 16'h0, 1, 1, 1, 16'h0000, "rd_edge_rst");
        add(8'h06, 16'h0, 1, 1, 1, 16'h0000, "rd_active_rst");
        add(8'h08, 16'h0, 1, 1, 1, 16'h0000, "rd_prio_lo_rst");
        add(8'h0A, 16'h0, 1, 1, 1, 16'h0000, "rd_prio_hi_rst");
        add(8'h0C, 16'h0, 1, 1, 1, 16'h0000, "rd_unmapped_0c");
        add(8'hFE, 16'h0, 1, 1, 1, 16'h0000, "rd_unmapped_fe");
        add(8'h02, 16'hFFFF, 1, 1, 0, 16'h0, "wr_enable");
        add(8'h03, 16'h0, 1, 1, 1, 16'h00FF, "rd_enable_odd_addr");
        add(8'h04, 16'hABCD, 1, 1, 0, 16'h0, "wr_edge");
        add(8'h04, 16'h0, 1, 1, 1, 16'h00CD, "rd_edge_mask");
        add(8'h08, 16'hFFFF, 1, 1, 0, 16'h0, "wr_prio_lo");
        add(8'h08, 16'h0, 1, 1, 1, 16'h7777, "rd_prio_lo_mask");
        add(8'h0A, 16'h1234, 1, 1, 0, 16'h0, "wr_prio_hi");
        add(8'h0A, 16'h5600, 1, 0, 0, 16'h0, "wr_prio_hi_uds");
        add(8'h0A, 16'h0, 1, 1, 1, 16'h5634, "rd_prio_hi_uds");
        add(8'h0C, 16'hFFFF, 1, 1, 0, 16'h0, "wr_unmapped");
        add(8'h0C, 16'h0, 1, 1, 1, 16'h0000, "rd_unmapped_after_wr");
        add(8'h06, 16'h0, 1, 1, 1, 16'h0000, "rd_active_none");
        for (int i = 0; i < vt.size(); i++) begin
            bus_access(vt[i].addr, vt[i].wdata, vt[i].uds, vt[i].lds, vt[i].rw,
                       vt[i].name, vt[i].exp);
        end
        check("ipl_no_pending", 16'(ipl_n), 16'h7);

        // Single edge source: latency and W1C.
        do_reset();
        wr(8'h04, 16'h0001);
        wr(8'h02, 16'h0001);
        wr(8'h08, 16'h0003);
        irq_src = 8'h01;
        @(posedge clk);
        #1;
        irq_src = 8'h00;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("ipl_before_e3", 16'(ipl_n), 16'h7);
        @(posedge clk);
        @(negedge clk);
        check("ipl_at_e3", 16'(ipl_n), 16'h4);
        @(posedge clk);
        #1;
        rd(8'h00, 16'h0001, "pending_t2");
        wr(8'h00, 16'h0001);
        check("ipl_after_w1c", 16'(ipl_n), 16'h7);

        // Priority arbitration with a tie.
        do_reset();
        wr(8'h04, 16'h0046);
        wr(8'h02, 16'h0046);
        wr(8'h08, 16'h0550);
        wr(8'h0A, 16'h0200);
        irq_src = 8'h46;
        wait_clks(1);
        irq_src = 8'h00;
        wait_clks(4);
        rd(8'h06, 16'h8001, "active_tie");
        check("ipl_lvl5", 16'(ipl_n), 16'h2);
        rd(8'h00, 16'h0046, "pending_t3");
        wr(8'h00, 16'h0002);
        rd(8'h06, 16'h8002, "active_after_clr1");
        wr(8'h00, 16'h0004);
        rd(8'h06, 16'h8006, "active_after_clr2");
        check("ipl_lvl2", 16'(ipl_n), 16'h5);

        // Level-mode source at level 7.
        do_reset();
        wr(8'h02, 16'h0008);
        wr(8'h08, 16'h7000);
        irq_src = 8'h08;
        wait_clks(4);
        check("ipl_lvl7", 16'(ipl_n), 16'h0);
        wr(8'h00, 16'h0008);
        rd(8'h00, 16'h0008, "pending_level_w1c");
        check("ipl_lvl7_after_w1c", 16'(ipl_n), 16'h0);
        irq_src = 8'h00;
        wait_clks(4);
        check("ipl_level_dropped", 16'(ipl_n), 16'h7);

        // Edge set coincident with W1C, then lower-lane-only write.
        do_reset();
        wr(8'h04, 16'h0001);
        wr(8'h02, 16'h0001);
        wr(8'h08, 16'h0001);
        irq_src = 8'h01;
        wait_clks(1);
        irq_src = 8'h00;
        wait_clks(1);
        wr(8'h00, 16'h0001);
        rd(8'h00, 16'h0001, "pending_set_wins");
        wr(8'h08, 16'h3412);
        bus_access(8'h08, 16'h00FF, 1'b0, 1'b1, 1'b0, "wr_prio_lo_lds", 16'h0);
        rd(8'h08, 16'h3477, "prio_lo_lds_only");

        // Reset during a held access, then a write issued under reset.
        do_reset();
        wr(8'h04, 16'h0001);
        wr(8'h02, 16'h0001);
        wr(8'h08, 16'h0004);
        irq_src = 8'h01;
        wait_clks(1);
        irq_src = 8'h00;
        wait_clks(4);
        check("ipl_lvl4", 16'(ipl_n), 16'h3);
        mon_e.name = "held_read";
        mon_e.data = 16'h0001;
        sb.push_back(mon_e);
        acks_exp++;
        bus.addr = 8'h00;
        bus.rw = 1'b1;
        bus.uds = 1'b1;
        bus.lds = 1'b1;
        wait_clks(1);
        check("ack_held", 16'(bus.ack), 16'h1);
        reset = 1'b1;
        wait_clks(1);
        check("ack_after_reset", 16'(bus.ack), 16'h0);
        check("ipl_after_reset", 16'(ipl_n), 16'h7);
        bus.rw = 1'b0;
        bus.addr = 8'h02;
        bus.data_write = 16'h00FF;
        wait_clks(1);
        check("ack_write_in_reset", 16'(bus.ack), 16'h0);
        reset = 1'b0;
        bus.uds = 1'b0;
        bus.lds = 1'b0;
        wait_clks(1);
        rd(8'h02, 16'h0000, "enable_after_abort");
        rd(8'h00, 16'h0000, "pending_after_abort");
        rd(8'h08, 16'h0000, "prio_lo_after_abort");

        wait_clks(2);
        check("ack_count", 16'(acks_seen), 16'(acks_exp));
        check("sb_drained", 16'(sb.size()), 16'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
